instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the 32-bit program ROM. Drives the ROM address and enables,

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the program ROM. It reads an opcode/operand pair, does an optional
// extra ROM data-read cycle, and issues the instruction to execute over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned ROM_DEPTH  = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [7:0]  HALT_OP    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] addr,
    output logic                  rom_enable,
    output logic                  rom_read_data_enable,
    input  logic [DATA_WIDTH-1:0] read_opcode,
    input  logic [DATA_WIDTH-1:0] read_operand,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  branch_valid,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic                  halted
);

    localparam int unsigned PC_WIDTH   = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [7:0]  DATA_RD_OP = 8'h31;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        ISSUE,
        HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target_pc;

    assign target_pc = branch_target[PC_WIDTH-1:0];

    // Outputs are registered alongside the state they belong to, so addr/enables are
    // already valid during the FETCH/DATA cycle that uses them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            pc                   <= '0;
            addr                 <= '0;
            rom_enable           <= 1'b0;
            rom_read_data_enable <= 1'b0;
            instr_valid          <= 1'b0;
            instr_opcode         <= '0;
            instr_operand        <= '0;
            instr_data           <= '0;
            instr_pc             <= '0;
            halted               <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state                <= FETCH;
                        addr                 <= DATA_WIDTH'(pc);
                        rom_enable           <= 1'b1;
                        rom_read_data_enable <= 1'b0;
                        halted               <= 1'b0;
                    end
                end

                FETCH: begin
                    if (branch_valid) begin
                        state <= FETCH;
                        pc    <= target_pc;
                        addr  <= DATA_WIDTH'(target_pc);
                    end else begin
                        instr_opcode  <= read_opcode;
                        instr_operand <= read_operand;
                        instr_pc      <= DATA_WIDTH'(pc);
                        instr_data    <= '0;
                        pc            <= pc + PC_WIDTH'(1);
                        if (read_opcode[15:8] == DATA_RD_OP) begin
                            state                <= DATA;
                            addr                 <= DATA_WIDTH'(pc);
                            rom_read_data_enable <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            rom_enable  <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    rom_read_data_enable <= 1'b0;
                    if (branch_valid) begin
                        state <= FETCH;
                        pc    <= target_pc;
                        addr  <= DATA_WIDTH'(target_pc);
                    end else begin
                        state       <= ISSUE;
                        instr_data  <= read_data;
                        rom_enable  <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end

                ISSUE: begin
                    // A redirect wins over both the normal refetch and the HALT transition.
                    if (branch_valid) begin
                        state       <= FETCH;
                        pc          <= target_pc;
                        addr        <= DATA_WIDTH'(target_pc);
                        rom_enable  <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (instr_opcode[15:8] == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            addr       <= DATA_WIDTH'(pc);
                            rom_enable <= 1'b1;
                        end
                    end
                end

                default: begin
                    state                <= IDLE;
                    rom_enable           <= 1'b0;
                    rom_read_data_enable <= 1'b0;
                    instr_valid          <= 1'b0;
                    halted               <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small ROM model; expected values hand-computed
// from the ROM image below.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] addr;
    logic        rom_enable;
    logic        rom_read_data_enable;
    logic [15:0] read_opcode;
    logic [15:0] read_operand;
    logic [15:0] read_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        halted;

    logic [31:0] rom [16];
    int          errors = 0;
    int          checks = 0;

    instr_fetch_unit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .addr                 (addr),
        .rom_enable           (rom_enable),
        .rom_read_data_enable (rom_read_data_enable),
        .read_opcode          (read_opcode),
        .read_operand         (read_operand),
        .read_data            (read_data),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr_opcode         (instr_opcode),
        .instr_operand        (instr_operand),
        .instr_data           (instr_data),
        .instr_pc             (instr_pc),
        .branch_valid         (branch_valid),
        .branch_target        (branch_target),
        .halted               (halted)
    );

    always #5 clk = ~clk;

    // Data reads return the low half of the ROM word named by the latched operand.
    assign read_opcode  = rom[addr[3:0]][31:16];
    assign read_operand = rom[addr[3:0]][15:0];
    assign read_data    = rom_read_data_enable ? rom[instr_operand[3:0]][15:0] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag, input logic [15:0] op, input logic [15:0] opnd,
                               input logic [15:0] data, input logic [15:0] pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".opcode"}, 32'(instr_opcode), 32'(op));
        check({tag, ".operand"}, 32'(instr_operand), 32'(opnd));
        check({tag, ".data"}, 32'(instr_data), 32'(data));
        check({tag, ".pc"}, 32'(instr_pc), 32'(pc));
    endtask

    task automatic check_fetch(input string tag, input logic [15:0] a);
        check({tag, ".addr"}, 32'(addr), 32'(a));
        check({tag, ".rom_en"}, 32'(rom_enable), 32'd1);
        check({tag, ".rd_en"}, 32'(rom_read_data_enable), 32'd0);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"}, 32'(addr), 32'd0);
        check({tag, ".enables"}, 32'({rom_enable, rom_read_data_enable}), 32'd0);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".instr"}, {instr_opcode, instr_operand}, 32'd0);
        check({tag, ".data_pc"}, {instr_data, instr_pc}, 32'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0]  = 32'h0100_0005;
        rom[1]  = 32'h0200_0007;
        rom[2]  = 32'h3100_0009;
        rom[3]  = 32'h0300_0011;
        rom[4]  = 32'hFF00_0000;
        rom[5]  = 32'h0500_0022;
        rom[9]  = 32'h0000_ABCD;
        rom[15] = 32'h0F00_0033;

        rst_n = 1'b1; start = 1'b0; instr_ready = 1'b0;
        branch_valid = 1'b0; branch_target = 16'h0;
        #2 rst_n = 1'b0;
        #10;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("idle.rom_en", 32'(rom_enable), 32'd0);

        // Two plain instructions back to back
        start = 1'b1;
        step();
        start = 1'b0;
        check_fetch("f0", 16'h0000);
        step();
        check_issue("i0", 16'h0100, 16'h0005, 16'h0000, 16'h0000);
        check("i0.rom_en", 32'(rom_enable), 32'd0);
        instr_ready = 1'b1;
        step();
        check_fetch("f1", 16'h0001);
        step();
        check_issue("i1", 16'h0200, 16'h0007, 16'h0000, 16'h0001);

        // Data-read instruction with a stalled consumer
        step();
        check_fetch("f2", 16'h0002);
        instr_ready = 1'b0;
        step();
        check("d2.addr", 32'(addr), 32'h0002);
        check("d2.enables", 32'({rom_enable, rom_read_data_enable}), 32'b11);
        check("d2.valid", 32'(instr_valid), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_issue("stall", 16'h3100, 16'h0009, 16'hABCD, 16'h0002);
            check("stall.enables", 32'({rom_enable, rom_read_data_enable}), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        step();
        check_fetch("f3", 16'h0003);
        step();
        check_issue("i3", 16'h0300, 16'h0011, 16'h0000, 16'h0003);

        // HALT and restart
        step();
        check_fetch("f4", 16'h0004);
        step();
        check_issue("i4", 16'hFF00, 16'h0000, 16'h0000, 16'h0004);
        step();
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.valid", 32'(instr_valid), 32'd0);
        check("halt.rom_en", 32'(rom_enable), 32'd0);
        step();
        check("halt.hold", 32'(halted), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_fetch("f5", 16'h0005);
        check("f5.halted", 32'(halted), 32'd0);
        step();
        check_issue("i5", 16'h0500, 16'h0022, 16'h0000, 16'h0005);

        // Redirect in ISSUE with handshake, then redirect during DATA
        branch_valid = 1'b1; branch_target = 16'h0002;
        step();
        branch_valid = 1'b0;
        check_fetch("br_f2", 16'h0002);
        step();
        check("br_d2.rd_en", 32'(rom_read_data_enable), 32'd1);
        branch_valid = 1'b1; branch_target = 16'h0003;
        step();
        branch_valid = 1'b0;
        check_fetch("br_f3", 16'h0003);
        step();
        check_issue("br_i3", 16'h0300, 16'h0011, 16'h0000, 16'h0003);

        // PC wrap from the last ROM word; upper target bits are ignored
        branch_valid = 1'b1; branch_target = 16'h00FF;
        step();
        branch_valid = 1'b0;
        check_fetch("f15", 16'h000F);
        step();
        check_issue("i15", 16'h0F00, 16'h0033, 16'h0000, 16'h000F);
        step();
        check_fetch("wrap", 16'h0000);
        step();
        check_issue("wrap_i0", 16'h0100, 16'h0005, 16'h0000, 16'h0000);

        // Asynchronous reset in the middle of a data read
        branch_valid = 1'b1; branch_target = 16'h0002;
        step();
        branch_valid = 1'b0;
        step();
        check("pre_rst.rd_en", 32'(rom_read_data_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
